// File: rtl/mfp_fft_frame_serializer.sv
// Captures one packed FFT frame in a single cycle and streams it out one bin
// per cycle over valid/ready, bin 0 first. Optional macro: MFP_FFT_SER_HALF_EN.
module mfp_fft_frame_serializer #(
    parameter int unsigned  FFTL = 8,
    parameter int unsigned  FFTW = 16,
    localparam int unsigned IDXW = $clog2(FFTL)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FFTW*FFTL-1:0]  DIn_R,
    input  logic [FFTW*FFTL-1:0]  DIn_I,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FFTW-1:0]       out_R,
    output logic [FFTW-1:0]       out_I,
    output logic [IDXW-1:0]       out_idx,
    output logic                  out_last
);

`ifdef MFP_FFT_SER_HALF_EN
    // Hermitian half: bins 0..FFTL/2 only
    localparam int unsigned LAST = FFTL / 2;
`else
    localparam int unsigned LAST = FFTL - 1;
`endif
    localparam int unsigned     NBUF     = LAST + 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LAST);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    logic [0:0]      state_q;
    logic [0:0]      state_d;
    logic [IDXW-1:0] idx_q;
    logic [IDXW-1:0] idx_d;
    logic            cap_c;
    logic            beat_c;
    logic            load_c;
    logic            advance_c;
    logic            finish_c;

    logic [FFTW-1:0] bin_r [NBUF];
    logic [FFTW-1:0] bin_i [NBUF];

`ifdef MFP_FFT_SER_HALF_EN
    // Upper bins of a real-input frame are redundant and never stored
    logic unused_hi_bins;
    assign unused_hi_bins = ^{DIn_R[FFTW*FFTL-1:FFTW*NBUF], DIn_I[FFTW*FFTL-1:FFTW*NBUF]};
`endif

    // Ready in the final-bin cycle too, so frames can follow with no bubble
    assign in_ready = (state_q == ST_IDLE) |
                      ((state_q == ST_STREAM) & out_last & out_ready);
    assign cap_c    = en & in_valid & in_ready;
    assign beat_c   = en & out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        load_c    = 1'b0;
        advance_c = 1'b0;
        finish_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cap_c) begin
                    state_d = ST_STREAM;
                    idx_d   = '0;
                    load_c  = 1'b1;
                end
            end
            ST_STREAM: begin
                if (beat_c) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (cap_c) begin
                            load_c = 1'b1;
                        end else begin
                            state_d  = ST_IDLE;
                            finish_c = 1'b1;
                        end
                    end else begin
                        idx_d     = idx_q + IDXW'(1);
                        advance_c = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Frame buffer and registered output bin
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NBUF; k++) begin
                bin_r[k] <= '0;
                bin_i[k] <= '0;
            end
            out_valid <= 1'b0;
            out_R     <= '0;
            out_I     <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else if (load_c) begin
            for (int unsigned k = 0; k < NBUF; k++) begin
                bin_r[k] <= DIn_R[k*FFTW +: FFTW];
                bin_i[k] <= DIn_I[k*FFTW +: FFTW];
            end
            out_valid <= 1'b1;
            out_R     <= DIn_R[FFTW-1:0];
            out_I     <= DIn_I[FFTW-1:0];
            out_idx   <= '0;
            out_last  <= (LAST_IDX == '0);
        end else if (advance_c) begin
            out_R    <= bin_r[idx_d];
            out_I    <= bin_i[idx_d];
            out_idx  <= idx_d;
            out_last <= (idx_d == LAST_IDX);
        end else if (finish_c) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mfp_fft_frame_serializer.sv
// Directed bench for mfp_fft_frame_serializer: cycle table plus a random-stall frame.
module tb_mfp_fft_frame_serializer;

    localparam int unsigned FFTL = 8;
    localparam int unsigned FFTW = 16;
    localparam int unsigned IDXW = 3;
`ifdef MFP_FFT_SER_HALF_EN
    localparam int L = FFTL / 2;
`else
    localparam int L = FFTL - 1;
`endif

    logic                 clk;
    logic                 rst;
    logic                 en;
    logic                 in_valid;
    logic                 in_ready;
    logic [FFTW*FFTL-1:0] DIn_R;
    logic [FFTW*FFTL-1:0] DIn_I;
    logic                 out_valid;
    logic                 out_ready;
    logic [FFTW-1:0]      out_R;
    logic [FFTW-1:0]      out_I;
    logic [IDXW-1:0]      out_idx;
    logic                 out_last;

    mfp_fft_frame_serializer #(.FFTL(FFTL), .FFTW(FFTW)) dut (
        .clk(clk), .rst(rst), .en(en),
        .in_valid(in_valid), .in_ready(in_ready),
        .DIn_R(DIn_R), .DIn_I(DIn_I),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_R(out_R), .out_I(out_I),
        .out_idx(out_idx), .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // efrm: frame id whose data is expected; -1 = all-zero outputs; -2 = data unchecked
    typedef struct {
        int   tid;
        logic rst;
        logic en;
        logic iv;
        logic ordy;
        int   frm;
        logic ev;
        int   eidx;
        logic elast;
        logic erdy;
        int   efrm;
    } vec_t;

    vec_t vq[$];
    int   n_vec;
    int   n_fail;
    int   cur_tid;

    function automatic logic [FFTW-1:0] fr(input int f, input int k);
        case (f)
            0:       return 16'(k * 16);
            1:       return 16'(100 + k);
            2:       return 16'h8000 | 16'(k);
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [FFTW-1:0] fi(input int f, input int k);
        case (f)
            0:       return 16'(-k);
            1:       return 16'(1000 * k);
            2:       return 16'(16'h7FF0 + k);
            default: return 16'h0000;
        endcase
    endfunction

    function automatic void add(input logic r, input logic e, input logic iv, input logic o,
                                input int frm, input logic ev, input int eidx,
                                input logic erdy, input int efrm);
        vec_t v;
        v.tid = cur_tid; v.rst = r; v.en = e; v.iv = iv; v.ordy = o; v.frm = frm;
        v.ev = ev; v.eidx = eidx; v.elast = ev && (eidx == L); v.erdy = erdy; v.efrm = efrm;
        vq.push_back(v);
    endfunction

    function automatic void add_bin(input logic e, input logic iv, input logic o,
                                    input int frm, input int k, input int efrm);
        add(1'b0, e, iv, o, frm, 1'b1, k, (k == L) && o, efrm);
    endfunction

    function automatic void add_idle(input logic iv, input int frm);
        add(1'b0, 1'b1, iv, 1'b1, frm, 1'b0, 0, 1'b1, -2);
    endfunction

    task automatic drive_frame(input int f);
        for (int k = 0; k < int'(FFTL); k++) begin
            DIn_R[k*FFTW +: FFTW] = fr(f, k);
            DIn_I[k*FFTW +: FFTW] = fi(f, k);
        end
    endtask

    task automatic apply(input vec_t v, input int row);
        logic ok;
        rst = v.rst; en = v.en; in_valid = v.iv; out_ready = v.ordy;
        drive_frame(v.frm);
        #2;
        ok = (out_valid === v.ev) && (in_ready === v.erdy);
        if (v.ev || v.efrm == -1)
            ok = ok && (out_idx === IDXW'(v.eidx)) && (out_last === v.elast);
        if (v.ev && v.efrm >= 0)
            ok = ok && (out_R === fr(v.efrm, v.eidx)) && (out_I === fi(v.efrm, v.eidx));
        if (v.efrm == -1)
            ok = ok && (out_R === 16'h0000) && (out_I === 16'h0000);
        n_vec++;
        if (!ok) begin
            n_fail++;
            $display("FAIL t%0d row %0d: got valid=%b idx=%0d R=%h I=%h last=%b rdy=%b; want valid=%b idx=%0d R=%h I=%h last=%b rdy=%b",
                     v.tid, row, out_valid, out_idx, out_R, out_I, out_last, in_ready,
                     v.ev, v.eidx, (v.efrm >= 0) ? fr(v.efrm, v.eidx) : 16'h0,
                     (v.efrm >= 0) ? fi(v.efrm, v.eidx) : 16'h0, v.elast, v.erdy);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c;
        int k;
        logic o;
        int exp_k;
        logic done;
        logic have_prev;
        logic [IDXW-1:0] prev_idx;
        logic [FFTW-1:0] prev_r;
        logic [FFTW-1:0] prev_i;

        n_vec = 0; n_fail = 0;

        // reset state
        cur_tid = 0;
        add(1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 0, 1'b1, -1);

        // single frame, full throughput; DIn changed after capture
        cur_tid = 1;
        add_idle(1'b1, 0);
        for (int i = 0; i <= L; i++) add_bin(1'b1, 1'b0, 1'b1, 2, i, 0);
        add_idle(1'b0, 2);

        // two frames back to back, in_valid held high
        cur_tid = 2;
        add_idle(1'b1, 1);
        for (int i = 0; i <= L; i++) add_bin(1'b1, 1'b1, 1'b1, 2, i, 1);
        for (int i = 0; i <= L; i++) add_bin(1'b1, 1'b0, 1'b1, 0, i, 2);
        add_idle(1'b0, 0);

        // out_ready 1,0,0,1,... with a pending frame that must wait
        cur_tid = 3;
        add_idle(1'b1, 0);
        c = 0; k = 0;
        while (k <= L) begin
            o = (c % 3 == 0);
            add_bin(1'b1, 1'b1, o, 1, k, 0);
            if (o) k++;
            c++;
        end

        // en=0 freezes mid-frame and on the last bin (no capture while frozen)
        cur_tid = 4;
        add_bin(1'b1, 1'b0, 1'b1, 0, 0, 1);
        add_bin(1'b1, 1'b0, 1'b1, 0, 1, 1);
        for (int i = 0; i < 3; i++) add_bin(1'b0, 1'b1, 1'b1, 0, 2, 1);
        for (int i = 2; i < L; i++) add_bin(1'b1, 1'b0, 1'b1, 0, i, 1);
        for (int i = 0; i < 3; i++) add_bin(1'b0, 1'b1, 1'b1, 0, L, 1);
        add_bin(1'b1, 1'b0, 1'b1, 0, L, 1);
        add_idle(1'b0, 0);

        // reset at idx 4 with en=0, then a fresh frame from idx 0
        cur_tid = 5;
        add_idle(1'b1, 2);
        for (int i = 0; i < 4; i++) add_bin(1'b1, 1'b0, 1'b1, 0, i, 2);
        add(1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b1, 4, (4 == L), 2);
        add(1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 0, 1'b1, -1);
        add(1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0, 0, 1'b1, -1);
        for (int i = 0; i <= L; i++) add_bin(1'b1, 1'b0, 1'b1, 1, i, 0);
        add_idle(1'b0, 1);

        // power-on reset, en low to show reset does not depend on it
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive_frame(0);
        @(posedge clk); @(posedge clk);
        #1;

        foreach (vq[i]) apply(vq[i], i);

        // random stall pattern over one frame, stability checked on every stall
        cur_tid = 6;
        rst = 1'b0; en = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        drive_frame(1);
        #2;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rs_idle: got rdy=%b valid=%b; want rdy=1 valid=0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        drive_frame(0);
        exp_k = 0; done = 1'b0; have_prev = 1'b0;
        prev_idx = '0; prev_r = '0; prev_i = '0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            #2;
            if (have_prev) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_idx !== prev_idx || out_R !== prev_r || out_I !== prev_i) begin
                    n_fail++;
                    $display("FAIL rs_hold: got valid=%b idx=%0d R=%h I=%h; want valid=1 idx=%0d R=%h I=%h",
                             out_valid, out_idx, out_R, out_I, prev_idx, prev_r, prev_i);
                end
            end
            n_vec++;
            if (out_valid !== 1'b1 || out_idx !== IDXW'(exp_k) || out_R !== fr(1, exp_k) ||
                out_I !== fi(1, exp_k) || out_last !== (exp_k == L) ||
                in_ready !== ((exp_k == L) && out_ready)) begin
                n_fail++;
                $display("FAIL rs_bin: got valid=%b idx=%0d R=%h I=%h last=%b rdy=%b; want idx=%0d R=%h I=%h",
                         out_valid, out_idx, out_R, out_I, out_last, in_ready,
                         exp_k, fr(1, exp_k), fi(1, exp_k));
            end
            have_prev = !out_ready;
            prev_idx = out_idx; prev_r = out_R; prev_i = out_I;
            if (out_ready) begin
                if (exp_k == L) done = 1'b1;
                exp_k++;
            end
            @(posedge clk); #1;
        end
        n_vec++;
        if (!done) begin
            n_fail++;
            $display("FAIL rs_timeout: got %0d beats in 200 cycles; want %0d", exp_k, L + 1);
        end
        #2;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rs_end: got valid=%b rdy=%b; want valid=0 rdy=1", out_valid, in_ready);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
